dec_timer: RTL and testbench

DEC_TIMER -- requirements
Module: dec_timer

---
 rtl/dec_timer_pkg.sv | 42 ++++
 rtl/dec_timer_seg7_dec.sv | 22 ++
 rtl/dec_timer.sv | 148 ++++++++++++++
 tb/tb_dec_timer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_timer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dec_timer_pkg : shared state type, segment patterns and BCD helper.      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package dec_timer_pkg;

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Active-low segments g..a, indexed by digit value.
  localparam logic [9:0][6:0] c_SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  function automatic logic [31:0] to_bcd(input int unsigned value);
    logic [31:0] bcd;
    int unsigned rest;
    bcd  = '0;
    rest = value;
    for (int i = 0; i < 8; i++) begin
      bcd[4*i +: 4] = 4'(rest % 10);
      rest          = rest / 10;
    end
    return bcd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_timer_seg7_dec.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seg7_dec : one BCD digit to active-low 7-segment pattern, with blanking. |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module seg7_dec
  import dec_timer_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = c_SEG_BLANK;
    if (!i_blank && (i_bcd <= 4'd9)) begin
      o_seg = c_SEG_TABLE[i_bcd];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dec_timer : prescaled up/down BCD counter with 7-segment outputs.        |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module dec_timer
  import dec_timer_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int NDIG     = 2,
  parameter int MAX_VAL  = 59,
  parameter int BLANK_LZ = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              CLR,
  input  logic              DOWN,
  output logic [4*NDIG-1:0] BCD,
  output logic [7*NDIG-1:0] HEX,
  output logic              RUN,
  output logic              WRAP
);

  localparam int              c_DIV      = CLK_HZ / TICK_HZ;
  localparam int              c_PW       = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(c_DIV - 1);
  localparam logic [4*NDIG-1:0] c_MAX_BCD = (4*NDIG)'(to_bcd(MAX_VAL));

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW-1:0]   r_pre;
  logic [4*NDIG-1:0] r_bcd;
  logic [4*NDIG-1:0] w_bcd_step;
  logic              r_wrap;
  logic              w_wrap_nxt;
  logic              w_run_en;
  logic              w_tick;
  logic [NDIG-1:0]   w_blank;

  always_comb begin
    w_state_nxt = r_state;
    if (STOP) begin
      w_state_nxt = ST_STOPPED;
    end else if (START) begin
      w_state_nxt = ST_RUNNING;
    end
  end

  // A STOP pulse freezes the prescaler on the very edge it is sampled.
  assign w_run_en = (r_state == ST_RUNNING) && !STOP;
  assign w_tick   = w_run_en && (r_pre == c_PRE_LAST);

  always_comb begin
    logic carry;
    w_bcd_step = r_bcd;
    w_wrap_nxt = 1'b0;
    carry      = 1'b1;
    if (DOWN) begin
      if (r_bcd == '0) begin
        w_bcd_step = c_MAX_BCD;
        w_wrap_nxt = 1'b1;
      end else begin
        for (int i = 0; i < NDIG; i++) begin
          if (carry) begin
            if (r_bcd[4*i +: 4] == 4'd0) begin
              w_bcd_step[4*i +: 4] = 4'd9;
            end else begin
              w_bcd_step[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
              carry                = 1'b0;
            end
          end
        end
      end
    end else begin
      if (r_bcd == c_MAX_BCD) begin
        w_bcd_step = '0;
        w_wrap_nxt = 1'b1;
      end else begin
        for (int i = 0; i < NDIG; i++) begin
          if (carry) begin
            if (r_bcd[4*i +: 4] == 4'd9) begin
              w_bcd_step[4*i +: 4] = 4'd0;
            end else begin
              w_bcd_step[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
              carry                = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_STOPPED;
      r_pre   <= '0;
      r_bcd   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= 1'b0;
      if (CLR) begin
        r_pre <= '0;
        r_bcd <= '0;
      end else if (w_run_en) begin
        if (w_tick) begin
          r_pre  <= '0;
          r_bcd  <= w_bcd_step;
          r_wrap <= w_wrap_nxt;
        end else begin
          r_pre <= r_pre + c_PW'(1);
        end
      end
    end
  end

  // Scan from the top digit down; blanking stops at the first non-zero digit.
  always_comb begin
    logic seen;
    w_blank = '0;
    seen    = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      w_blank[i] = (BLANK_LZ != 0) && !seen;
    end
  end

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      seg7_dec u_seg7_dec (
        .i_bcd   (r_bcd[4*gi +: 4]),
        .i_blank (w_blank[gi]),
        .o_seg   (HEX[7*gi +: 7])
      );
    end
  endgenerate

  assign BCD  = r_bcd;
  assign RUN  = (r_state == ST_RUNNING);
  assign WRAP = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dec_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dec_timer : directed scenarios plus random run against a value model. |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_dec_timer;

  localparam int A_DIV = 10;
  localparam int A_MAX = 59;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start_a = 1'b0, stop_a = 1'b0, clr_a = 1'b0, down_a = 1'b0;
  logic [7:0]  bcd_a;
  logic [13:0] hex_a;
  logic        run_a, wrap_a;

  logic start_b = 1'b0, stop_b = 1'b0, clr_b = 1'b0, down_b = 1'b0;
  logic [11:0] bcd_b;
  logic [20:0] hex_b;
  logic        run_b, wrap_b;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  dec_timer #(.CLK_HZ(10), .TICK_HZ(1), .NDIG(2), .MAX_VAL(59), .BLANK_LZ(0)) u_dut_a (
    .CLK(clk), .RST(rst_n), .START(start_a), .STOP(stop_a), .CLR(clr_a), .DOWN(down_a),
    .BCD(bcd_a), .HEX(hex_a), .RUN(run_a), .WRAP(wrap_a)
  );

  dec_timer #(.CLK_HZ(4), .TICK_HZ(1), .NDIG(3), .MAX_VAL(120), .BLANK_LZ(1)) u_dut_b (
    .CLK(clk), .RST(rst_n), .START(start_b), .STOP(stop_b), .CLR(clr_b), .DOWN(down_b),
    .BCD(bcd_b), .HEX(hex_b), .RUN(run_b), .WRAP(wrap_b)
  );

  // Reference model for instance A: decimal value plus elapsed running cycles.
  int m_val = 0;
  int m_pre = 0;
  bit m_run = 1'b0;
  bit m_wrap = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val <= 0; m_pre <= 0; m_run <= 1'b0; m_wrap <= 1'b0;
    end else begin
      m_wrap <= 1'b0;
      if (stop_a) m_run <= 1'b0;
      else if (start_a) m_run <= 1'b1;
      if (clr_a) begin
        m_val <= 0; m_pre <= 0;
      end else if (m_run && !stop_a) begin
        if (m_pre == A_DIV - 1) begin
          m_pre <= 0;
          if (down_a) begin
            if (m_val == 0) begin m_val <= A_MAX; m_wrap <= 1'b1; end
            else m_val <= m_val - 1;
          end else begin
            if (m_val == A_MAX) begin m_val <= 0; m_wrap <= 1'b1; end
            else m_val <= m_val + 1;
          end
        end else begin
          m_pre <= m_pre + 1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_bcd_a(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] exp_hex_a(input int v);
    return {seg_ref[(v / 10) % 10], seg_ref[v % 10]};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bcd_a !== 8'h00) begin errors++; $display("FAIL reset_bcd got %h want 00", bcd_a); end
    checks++; if (hex_a !== {7'h40, 7'h40}) begin errors++; $display("FAIL reset_hex got %h want %h", hex_a, {7'h40, 7'h40}); end
    checks++; if (run_a !== 1'b0 || wrap_a !== 1'b0) begin errors++; $display("FAIL reset_run_wrap got %b%b want 00", run_a, wrap_a); end
    checks++; if (hex_b !== {7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL reset_hex_b got %h want %h", hex_b, {7'h7F, 7'h7F, 7'h40}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_count();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL start_run got %b want 1", run_a); end
      end
      if (k == 9) begin
        checks++; if (bcd_a !== 8'h00) begin errors++; $display("FAIL early_tick got %h want 00", bcd_a); end
      end
      if (k == 10) begin
        checks++; if (bcd_a !== 8'h01) begin errors++; $display("FAIL first_tick got %h want 01", bcd_a); end
      end
      if (k == 20) begin
        checks++; if (bcd_a !== 8'h02 || run_a !== 1'b1) begin errors++; $display("FAIL second_tick got %h run %b want 02 run 1", bcd_a, run_a); end
      end
    end
  endtask

  task automatic test_wrap();
    bit found;
    logic [7:0] prev;
    down_a = 1'b1;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin
      @(negedge clk);
      if (wrap_a) found = 1'b1;
    end
    checks++; if (!found || bcd_a !== 8'h59) begin errors++; $display("FAIL wrap_down got %h wrap_seen %b want 59 1", bcd_a, found); end
    @(negedge clk);
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL wrap_down_width got %b want 0", wrap_a); end
    down_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin
      @(negedge clk);
      if (wrap_a) found = 1'b1;
    end
    checks++; if (!found || bcd_a !== 8'h00) begin errors++; $display("FAIL wrap_up got %h wrap_seen %b want 00 1", bcd_a, found); end
    @(negedge clk);
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL wrap_up_width got %b want 0", wrap_a); end
    found = 1'b0;
    for (int k = 0; k < 110 && !found; k++) begin
      @(negedge clk);
      if (bcd_a === 8'h10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL carry_to_10 got %h want 10", bcd_a); end
    down_a = 1'b1;
    prev = bcd_a;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (bcd_a !== prev) found = 1'b1;
    end
    checks++; if (!found || bcd_a !== 8'h09 || wrap_a !== 1'b0) begin errors++; $display("FAIL borrow_10 got %h wrap %b want 09 0", bcd_a, wrap_a); end
  endtask

  task automatic test_stop_resume();
    down_a = 1'b0;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    repeat (4) @(negedge clk);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL stop_run got %b want 0", run_a); end
    repeat (20) @(negedge clk);
    checks++; if (bcd_a !== 8'h00) begin errors++; $display("FAIL stopped_hold got %h want 00", bcd_a); end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        checks++; if (bcd_a !== 8'h00) begin errors++; $display("FAIL resume_early got %h want 00", bcd_a); end
      end
      if (k == 6) begin
        checks++; if (bcd_a !== 8'h01) begin errors++; $display("FAIL resume_tick got %h want 01", bcd_a); end
      end
    end
    start_a = 1'b1; stop_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; stop_a = 1'b0;
    checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL start_stop_running got %b want 0", run_a); end
    start_a = 1'b1; stop_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; stop_a = 1'b0;
    checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL start_stop_stopped got %b want 0", run_a); end
  endtask

  task automatic test_clr();
    start_a = 1'b1; clr_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; clr_a = 1'b0;
    checks++; if (run_a !== 1'b1 || bcd_a !== 8'h00) begin errors++; $display("FAIL start_clr got run %b bcd %h want 1 00", run_a, bcd_a); end
    down_a = 1'b1;
    repeat (9) @(negedge clk);
    checks++; if (bcd_a !== 8'h00) begin errors++; $display("FAIL pre_clr got %h want 00", bcd_a); end
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    checks++; if (bcd_a !== 8'h00 || wrap_a !== 1'b0 || run_a !== 1'b1) begin errors++; $display("FAIL clr_tick got bcd %h wrap %b run %b want 00 0 1", bcd_a, wrap_a, run_a); end
    @(negedge clk);
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL clr_wrap_after got %b want 0", wrap_a); end
  endtask

  task automatic test_reset_mid();
    down_a = 1'b0;
    repeat (24) @(negedge clk);
    checks++; if (bcd_a !== 8'h02) begin errors++; $display("FAIL pre_reset got %h want 02", bcd_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bcd_a !== 8'h00 || run_a !== 1'b0 || wrap_a !== 1'b0) begin errors++; $display("FAIL async_reset got bcd %h run %b wrap %b want 00 0 0", bcd_a, run_a, wrap_a); end
    checks++; if (hex_a !== {7'h40, 7'h40}) begin errors++; $display("FAIL async_reset_hex got %h want %h", hex_a, {7'h40, 7'h40}); end
    repeat (12) @(negedge clk);
    checks++; if (wrap_a !== 1'b0 || bcd_a !== 8'h00) begin errors++; $display("FAIL reset_hold got bcd %h wrap %b want 00 0", bcd_a, wrap_a); end
    rst_n = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL start_after_reset got %b want 1", run_a); end
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
  endtask

  task automatic test_blank();
    start_b = 1'b1; clr_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; clr_b = 1'b0;
    checks++; if (hex_b !== {7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL blank_zero got %h want %h", hex_b, {7'h7F, 7'h7F, 7'h40}); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) begin
        checks++; if (bcd_b !== 12'h005 || hex_b !== {7'h7F, 7'h7F, 7'h12}) begin errors++; $display("FAIL blank_005 got bcd %h hex %h want 005 %h", bcd_b, hex_b, {7'h7F, 7'h7F, 7'h12}); end
      end
      if (k == 40) begin
        checks++; if (bcd_b !== 12'h010 || hex_b !== {7'h7F, 7'h79, 7'h40}) begin errors++; $display("FAIL blank_010 got bcd %h hex %h want 010 %h", bcd_b, hex_b, {7'h7F, 7'h79, 7'h40}); end
      end
    end
    stop_b = 1'b1;
    @(negedge clk);
    stop_b = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if (bcd_a !== exp_bcd_a(m_val)) begin
        errors++; if (errors < 20) $display("FAIL rand_bcd cycle %0d got %h want %h", n, bcd_a, exp_bcd_a(m_val));
      end
      checks++;
      if (hex_a !== exp_hex_a(m_val)) begin
        errors++; if (errors < 20) $display("FAIL rand_hex cycle %0d got %h want %h", n, hex_a, exp_hex_a(m_val));
      end
      checks++;
      if (run_a !== m_run || wrap_a !== m_wrap) begin
        errors++; if (errors < 20) $display("FAIL rand_run_wrap cycle %0d got %b%b want %b%b", n, run_a, wrap_a, m_run, m_wrap);
      end
      checks++;
      if (bcd_a[3:0] > 4'd9 || bcd_a[7:4] > 4'd9) begin
        errors++; if (errors < 20) $display("FAIL rand_digit_range cycle %0d got %h want digits 0..9", n, bcd_a);
      end
      start_a = ($urandom_range(0, 19) == 0);
      stop_a  = ($urandom_range(0, 39) == 0);
      clr_a   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) down_a = ~down_a;
    end
    start_a = 1'b0; stop_a = 1'b0; clr_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_count();
    test_wrap();
    test_stop_resume();
    test_clr();
    test_reset_mid();
    test_blank();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
